pelican_mac_ctrl: RTL
=====================

# pelican_mac_ctrl

Job sequencer for the Pelican MAC core. It accepts one MAC job (IV, key, NUM_BLK message blocks) over a valid/ready stream and buffers it completely, because the core cannot stall. It then releases the core from reset, answers the core's key and message load strobes with the right 128-bit word, and holds the tag on a valid/ready output until it is taken. It sits between the system bus adapter and the MAC core instance.

## Interface
- NUM_BLK, 4, message blocks per job; must equal the core's block count (core MSG_NUM+1); legal range 1..8.
- TIMEOUT, 255, core-run cycle limit; used only when the watchdog is compiled in.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  controller accepts the input word.
- in_data  in  128  job word; words arrive in the order IV, key, block 0 .. block NUM_BLK-1.
- tag_valid  out  1  tag available.
- tag_ready  in  1  consumer accepts the tag.
- tag  out  128  MAC tag.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky protocol error; cleared only by rst.
- core_rst  out  1  reset to the core.
- core_load_iv  out  1  IV load strobe to the core.
- core_din  out  128  data bus to the core.
- core_load_k  in  1  core is sampling the key (level).
- core_load_m  in  1  core samples a message block on the following cycle (1-cycle pulse).
- core_dout  in  128  core state / tag.
- core_done  in  1  core finished (level, held).

## Operation
- FSM states: IDLE, COLLECT, IVLD, RUN, TAG.
- IDLE: in_ready=1. A word accepted (in_valid & in_ready) writes the IV register, sets the word count to 1 and moves to COLLECT.
- COLLECT: in_ready=1. Word 1 writes the key register. Words 2..NUM_BLK+1 write blk[cnt-2]. On the last word the FSM moves to IVLD.
- IVLD: lasts 1 cycle. core_rst=1, core_load_iv=1, core_din=IV. The FSM then moves to RUN and clears idx to 0.
- RUN: core_rst=0 and in_ready=0.
  - core_din = key while core_load_k=1; otherwise core_din = blk[idx].
  - m_d is core_load_m registered. idx increments on every cycle where m_d=1.
  - A core_load_m pulse while idx==NUM_BLK sets err and is otherwise ignored.
  - When core_done=1, tag is captured from core_dout and the FSM moves to TAG.
- TAG: tag_valid=1 and core_rst=1. When tag_ready=1, the FSM moves to IDLE.
- core_rst=1 in IDLE, COLLECT, IVLD and TAG. The core is therefore always cleared between jobs.
- Word and idx counters are $clog2(NUM_BLK+2) bits and saturate; they do not wrap.
- The key register is held for the whole RUN. The core requests the key twice per job: at start and before the final encryption.

## Timing
- Reset values: in_ready=0 during the reset cycle and 1 afterwards (state IDLE); tag_valid=0, tag=0, busy=0, err=0, core_rst=1, core_load_iv=0, core_din=0.
- Input intake is 1 word per cycle with no bubbles: NUM_BLK+2 cycles minimum.
- IVLD to the first core_load_k: 2 cycles (the core passes through its idle state).
- For NUM_BLK=4 with the matching core, RUN lasts 149 cycles to core_done.
- tag_valid rises on the cycle after core_done is sampled. It holds, with tag stable, until tag_ready.
- tag_ready low stalls indefinitely. The core stays in reset and no new input is accepted.
- rst in any state aborts the job immediately. All buffers are discarded and the next cycle is IDLE.
- in_valid is ignored outside IDLE and COLLECT. No word is consumed.

## Configuration
- PELICAN_CTRL_TIMEOUT_EN defined:
  - A watchdog counts RUN cycles.
  - On reaching TIMEOUT without core_done, it sets err and forces tag=0, tag_valid=1 (state TAG), so the job completes with a poisoned tag.
- PELICAN_CTRL_TIMEOUT_EN undefined: there is no counter, and RUN waits for core_done indefinitely.

## Structure
- Shared package pelican_pkg:
  - state enum (IDLE, COLLECT, IVLD, RUN, TAG)
  - BLK_W=128
  - DEF_NUM_BLK=4
  - DEF_TIMEOUT=255
- One sub-module, pelican_job_buf: IV, key and NUM_BLK block registers, with a write port indexed by word count and a read mux indexed by idx/key select.

## Test plan
- Nominal job: IV=0, key=000102..0F, blocks=all 0x11/0x22/0x33/0x44 against the real core.
  - Expect exactly 2 key windows and 4 load_m pulses, each answered with the correct block.
  - Expect tag equal to the reference model's tag.
- Gapped input: in_valid toggling 1/0 on alternate cycles.
  - Expect all 6 words captured in order and the same tag as the nominal job.
- Tag backpressure: tag_ready held low 50 cycles after tag_valid.
  - Expect tag stable and in_ready=0 throughout; tag accepted on the first ready cycle, then IDLE.
- Reset mid-RUN: assert rst 30 cycles into RUN.
  - Expect IDLE, busy=0 and core_rst=1 the next cycle.
  - A fresh job then produces the correct tag.
- Stub core issues 5 load_m pulses with NUM_BLK=4: expect err=1 after the fifth pulse and err remaining set.
- With PELICAN_CTRL_TIMEOUT_EN defined, a stub core that never asserts done: expect err=1 and tag_valid=1 with tag=0 at RUN cycle 255.

Source files
------------

// File: rtl/pelican_pkg.sv
// Shared types and constants for the Pelican MAC job sequencer.
package pelican_pkg;

  localparam int BLK_W       = 128;
  localparam int DEF_NUM_BLK = 4;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    IVLD,
    RUN,
    TAG
  } state_e;

endpackage

// File: rtl/pelican_mac_ctrl_if.sv
// Job input stream and tag output stream between the bus adapter and the
// Pelican MAC job sequencer.
interface pelican_mac_ctrl_if;
  import pelican_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] in_data;
  logic             tag_valid;
  logic             tag_ready;
  logic [BLK_W-1:0] tag;

  modport master (
    output in_valid, in_data, tag_ready,
    input  in_ready, tag_valid, tag
  );

  modport slave (
    input  in_valid, in_data, tag_ready,
    output in_ready, tag_valid, tag
  );

endinterface

// File: rtl/pelican_job_buf.sv
// Job buffer: IV, key and NUM_BLK message block registers. Written by word
// position (0 = IV, 1 = key, 2.. = blocks), read by block index or key select.
module pelican_job_buf
  import pelican_pkg::*;
#(
  parameter int NUM_BLK = DEF_NUM_BLK,
  parameter int CW      = $clog2(DEF_NUM_BLK + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [CW-1:0]    wr_sel_i,
  input  logic [BLK_W-1:0] wr_data_i,
  input  logic             rd_key_i,
  input  logic [CW-1:0]    rd_idx_i,
  output logic [BLK_W-1:0] iv_o,
  output logic [BLK_W-1:0] rd_data_o
);

  logic [BLK_W-1:0] iv_q;
  logic [BLK_W-1:0] key_q;
  logic [BLK_W-1:0] blk_q [NUM_BLK];

  // Store the accepted word in the slot chosen by its position in the job;
  // reset discards the whole job.
  always_ff @(posedge clk) begin
    if (rst) begin
      iv_q  <= '0;
      key_q <= '0;
      for (int i = 0; i < NUM_BLK; i++) blk_q[i] <= '0;
    end else if (wr_en_i) begin
      if (wr_sel_i == CW'(0)) iv_q <= wr_data_i;
      if (wr_sel_i == CW'(1)) key_q <= wr_data_i;
      for (int i = 0; i < NUM_BLK; i++) begin
        if (wr_sel_i == CW'(i + 2)) blk_q[i] <= wr_data_i;
      end
    end
  end

  // Key wins while selected; an index past the last block reads as zero.
  always_comb begin
    rd_data_o = '0;
    if (rd_key_i) begin
      rd_data_o = key_q;
    end else begin
      for (int i = 0; i < NUM_BLK; i++) begin
        if (rd_idx_i == CW'(i)) rd_data_o = blk_q[i];
      end
    end
  end

  assign iv_o = iv_q;

endmodule

// File: rtl/pelican_mac_ctrl.sv
// Pelican MAC job sequencer: buffers a whole job (IV, key, NUM_BLK blocks),
// then runs the core and serves its key/message strobes, and holds the tag
// until the consumer takes it.
// Optional watchdog: define PELICAN_CTRL_TIMEOUT_EN to bound RUN to TIMEOUT
// cycles; on expiry err is set and a zero tag is delivered.
module pelican_mac_ctrl
  import pelican_pkg::*;
#(
  parameter int NUM_BLK = DEF_NUM_BLK,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  pelican_mac_ctrl_if.slave bus,
  output logic             busy,
  output logic             err,
  output logic             core_rst,
  output logic             core_load_iv,
  output logic [BLK_W-1:0] core_din,
  input  logic             core_load_k,
  input  logic             core_load_m,
  input  logic [BLK_W-1:0] core_dout,
  input  logic             core_done
);

  localparam int            CW        = $clog2(NUM_BLK + 2);
  localparam logic [CW-1:0] LAST_WORD = CW'(NUM_BLK + 1);
  localparam logic [CW-1:0] MAX_IDX   = CW'(NUM_BLK);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             m_q, m_d;
  logic             err_q, err_d;
  logic [BLK_W-1:0] tag_q, tag_d;

  logic             ready;
  logic             accept;
  logic [CW-1:0]    wr_sel;
  logic             rd_key;
  logic [BLK_W-1:0] iv_word;
  logic [BLK_W-1:0] rd_word;
  logic             wd_expired;

  assign ready  = !rst && (state_q == IDLE || state_q == COLLECT);
  assign accept = ready && bus.in_valid;
  assign wr_sel = (state_q == IDLE) ? '0 : cnt_q;
  assign m_d    = (state_q == RUN) && core_load_m;

  pelican_job_buf #(
    .NUM_BLK (NUM_BLK),
    .CW      (CW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (accept),
    .wr_sel_i  (wr_sel),
    .wr_data_i (bus.in_data),
    .rd_key_i  (rd_key),
    .rd_idx_i  (idx_q),
    .iv_o      (iv_word),
    .rd_data_o (rd_word)
  );

`ifdef PELICAN_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wd_q;

  // Watchdog counts cycles spent in RUN and restarts outside it.
  always_ff @(posedge clk) begin
    if (rst || state_q != RUN) begin
      wd_q <= '0;
    end else if (wd_q != TW'(TIMEOUT)) begin
      wd_q <= wd_q + 1'b1;
    end
  end

  assign wd_expired = (wd_q == TW'(TIMEOUT - 1));
`else
  assign wd_expired = 1'b0;
`endif

  // State, counters, sticky error and captured tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      m_q     <= 1'b0;
      err_q   <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      m_q     <= m_d;
      err_q   <= err_d;
      tag_q   <= tag_d;
    end
  end

  // Next-state and core-facing outputs; the core is held in reset everywhere
  // except RUN so it always starts a job from a clean state.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    err_d         = err_q;
    tag_d         = tag_q;
    core_rst      = 1'b1;
    core_load_iv  = 1'b0;
    core_din      = '0;
    rd_key        = 1'b0;
    bus.tag_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = CW'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          if (cnt_q == LAST_WORD) state_d = IVLD;
          else                    cnt_d   = cnt_q + 1'b1;
        end
      end
      IVLD: begin
        core_load_iv = 1'b1;
        core_din     = iv_word;
        idx_d        = '0;
        state_d      = RUN;
      end
      RUN: begin
        core_rst = rst;
        rd_key   = core_load_k;
        core_din = rd_word;
        if (m_q && idx_q != MAX_IDX) idx_d = idx_q + 1'b1;
        if (core_load_m && idx_q == MAX_IDX) err_d = 1'b1;
        if (core_done) begin
          tag_d   = core_dout;
          state_d = TAG;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          tag_d   = '0;
          state_d = TAG;
        end
      end
      TAG: begin
        bus.tag_valid = 1'b1;
        if (bus.tag_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready = ready;
  assign bus.tag      = tag_q;
  assign busy         = (state_q != IDLE);
  assign err          = err_q;

endmodule
